// File: rtl/fixed_mac_pkg.sv
// fixed_mac_pkg: shared rounding-mode type and width/range helpers for the fixed-point MAC family
package fixed_mac_pkg;

    typedef enum logic {
        RND_TRUNC   = 1'b0,
        RND_HALF_UP = 1'b1
    } rnd_mode_e;

    function automatic int prod_w(input int wi1, input int wf1, input int wi2, input int wf2);
        return wi1 + wf1 + wi2 + wf2;
    endfunction

    function automatic int acc_w(input int pw, input int lanes, input int extra);
        return pw + $clog2(lanes) + extra;
    endfunction

    function automatic longint out_max(input int ow);
        return (longint'(1) << (ow - 1)) - 1;
    endfunction

    function automatic longint out_min(input int ow);
        return -(longint'(1) << (ow - 1));
    endfunction

endpackage

// File: rtl/fixed_requant.sv
// fixed_requant: combinational requantiser from PF-fraction accumulator to signed WIO.WFO
//  acc     in  ACC_W    signed accumulator, PF fraction bits
//  of_sat  in  1        clamp to max on overflow (else wrap)
//  uf_sat  in  1        clamp to min on underflow (else wrap)
//  data    out WIO+WFO  requantised result
//  ovf/unf out 1        rounded value above max / below min
module fixed_requant
    import fixed_mac_pkg::*;
#(
    parameter int        ACC_W = 33,
    parameter int        PF    = 18,
    parameter int        WIO   = 7,
    parameter int        WFO   = 13,
    parameter rnd_mode_e RND   = RND_TRUNC
) (
    input  logic signed [ACC_W-1:0]   acc,
    input  logic                      of_sat,
    input  logic                      uf_sat,
    output logic        [WIO+WFO-1:0] data,
    output logic                      ovf,
    output logic                      unf
);
    localparam int OW  = WIO + WFO;
    localparam int UP  = WFO > PF ? WFO - PF : 0;
    localparam int DN  = PF > WFO ? PF - WFO : 0;
    localparam int RW0 = ACC_W + UP + 1;
    // One spare bit so the half-LSB add can never wrap before the range check
    localparam int RW  = RW0 > OW + 1 ? RW0 : OW + 1;
    localparam logic signed [RW-1:0] HALF =
        (RND == RND_HALF_UP && DN > 0) ? RW'(1) <<< (DN > 0 ? DN - 1 : 0) : '0;
    localparam logic signed [RW-1:0] MAXV = RW'(out_max(OW));
    localparam logic signed [RW-1:0] MINV = RW'(out_min(OW));

    logic signed [RW-1:0] scaled;

    // Arithmetic right shift gives floor, so round-half-up is add-half-then-floor
    assign scaled = ((RW'(acc) <<< UP) + HALF) >>> DN;
    assign ovf    = scaled > MAXV;
    assign unf    = scaled < MINV;
    assign data   = (ovf & of_sat) ? MAXV[OW-1:0] : (unf & uf_sat) ? MINV[OW-1:0] : scaled[OW-1:0];

endmodule

// File: rtl/fixed_dot_mac.sv
// fixed_dot_mac: streaming multi-lane fixed-point dot-product accumulator with requantised output
//  clk, reset                 rising-edge clock, async active-low reset
//  A_data/A_valid/A_last/A_ready  LANES x Q(WI1.WF1) stream
//  B_data/B_valid/B_last/B_ready  LANES x Q(WI2.WF2) stream, joined with A
//  out_data/out_valid/out_ready   Q(WIO.WFO) frame result
//  OF_saturation, UF_saturation   clamp (1) or wrap (0) on overflow / underflow
//  overflow, underflow, last_err  result flags, valid with out_valid
module fixed_dot_mac
    import fixed_mac_pkg::*;
#(
    parameter int WI1   = 6,
    parameter int WF1   = 10,
    parameter int WI2   = 4,
    parameter int WF2   = 8,
    parameter int WIO   = 7,
    parameter int WFO   = 13,
    parameter int LANES = 2,
    parameter int Extra = 4,
    parameter int RND   = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [LANES*(WI1+WF1)-1:0]       A_data,
    input  logic                             A_valid,
    input  logic                             A_last,
    output logic                             A_ready,
    input  logic [LANES*(WI2+WF2)-1:0]       B_data,
    input  logic                             B_valid,
    input  logic                             B_last,
    output logic                             B_ready,
    output logic [WIO+WFO-1:0]               out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    input  logic                             OF_saturation,
    input  logic                             UF_saturation,
    output logic                             overflow,
    output logic                             underflow,
    output logic                             last_err
);
    localparam int AW    = WI1 + WF1;
    localparam int BW    = WI2 + WF2;
    localparam int PW    = prod_w(WI1, WF1, WI2, WF2);
    localparam int PF    = WF1 + WF2;
    localparam int ACC_W = acc_w(PW, LANES, Extra);
    localparam int OW    = WIO + WFO;

    logic                    s1_v_q, s1_v_d, s1_last_q, s1_last_d, s1_err_q, s1_err_d;
    logic [LANES*PW-1:0]     prod_q, prod_d;
    logic                    s2_last_q, s2_last_d, s2_err_q, s2_err_d, first_q, first_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, sum;
    logic                    out_valid_q, out_valid_d, ovf_q, ovf_d, unf_q, unf_d, err_q, err_d;
    logic [OW-1:0]           out_data_q, out_data_d, rq_data;
    logic                    rq_ovf, rq_unf, rdy, fire, ld, clr;

    fixed_requant #(
        .ACC_W (ACC_W),
        .PF    (PF),
        .WIO   (WIO),
        .WFO   (WFO),
        .RND   (rnd_mode_e'(RND))
    ) u_requant (
        .acc    (acc_q),
        .of_sat (OF_saturation),
        .uf_sat (UF_saturation),
        .data   (rq_data),
        .ovf    (rq_ovf),
        .unf    (rq_unf)
    );

    always_comb begin
        // A closing beat anywhere in S1/S2 blocks intake, so frames never overlap in the accumulator
        rdy         = reset & ~(out_valid_q & ~out_ready) & ~s1_last_q & ~s2_last_q;
        fire        = A_valid & B_valid & rdy;
        ld          = s2_last_q & (~out_valid_q | out_ready);
        clr         = out_valid_q & out_ready;
        s1_v_d      = fire;
        s1_last_d   = fire & (A_last | B_last);
        s1_err_d    = fire & (A_last ^ B_last);
        prod_d      = '0;
        sum         = '0;
        for (int i = 0; i < LANES; i++) begin
            prod_d[i*PW +: PW] = PW'($signed(A_data[i*AW +: AW])) * PW'($signed(B_data[i*BW +: BW]));
            sum                = sum + ACC_W'($signed(prod_q[i*PW +: PW]));
        end
        acc_d       = s1_v_q ? (first_q ? '0 : acc_q) + sum : acc_q;
        first_d     = s1_v_q ? s1_last_q : first_q;
        // A closing beat waits in S2 while the previous result is still unaccepted
        s2_last_d   = s1_v_q ? s1_last_q : s2_last_q & ~ld;
        s2_err_d    = s1_v_q ? s1_err_q : s2_err_q;
        out_valid_d = ld | (out_valid_q & ~out_ready);
        out_data_d  = ld ? rq_data : clr ? '0 : out_data_q;
        ovf_d       = ld ? rq_ovf : ~clr & ovf_q;
        unf_d       = ld ? rq_unf : ~clr & unf_q;
        err_d       = ld ? s2_err_q : ~clr & err_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_v_q      <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_err_q    <= 1'b0;
            prod_q      <= '0;
            s2_last_q   <= 1'b0;
            s2_err_q    <= 1'b0;
            first_q     <= 1'b1;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            s1_v_q      <= s1_v_d;
            s1_last_q   <= s1_last_d;
            s1_err_q    <= s1_err_d;
            prod_q      <= prod_d;
            s2_last_q   <= s2_last_d;
            s2_err_q    <= s2_err_d;
            first_q     <= first_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            err_q       <= err_d;
        end
    end

    assign A_ready   = rdy & B_valid;
    assign B_ready   = rdy & A_valid;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign last_err  = err_q;

endmodule

// File: tb/tb_fixed_dot_mac.sv
// tb_fixed_dot_mac: scoreboard bench for fixed_dot_mac, truncating and rounding instances side by side
module tb_fixed_dot_mac;

    typedef struct packed {
        logic [19:0] d;
        logic        o;
        logic        u;
        logic        e;
    } exp_t;

    logic        clk = 0, reset = 0;
    logic [31:0] A_data = '0;
    logic [23:0] B_data = '0;
    logic        A_valid = 0, A_last = 0, B_valid = 0, B_last = 0;
    logic        out_ready = 0, OF_saturation = 0, UF_saturation = 0;
    logic        ar[2], br[2], ov[2], ovf_w[2], unf_w[2], le_w[2];
    logic [19:0] od[2];

    exp_t   q0[$], q1[$];
    int     checks = 0, errors = 0;
    longint macc = 0;
    bit     mfirst = 1, of_next = 0, uf_next = 0, hold = 0;

    always #5 clk = ~clk;

    fixed_dot_mac #(.RND(0)) u0 (
        .clk(clk), .reset(reset),
        .A_data(A_data), .A_valid(A_valid), .A_last(A_last), .A_ready(ar[0]),
        .B_data(B_data), .B_valid(B_valid), .B_last(B_last), .B_ready(br[0]),
        .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready),
        .OF_saturation(OF_saturation), .UF_saturation(UF_saturation),
        .overflow(ovf_w[0]), .underflow(unf_w[0]), .last_err(le_w[0])
    );

    fixed_dot_mac #(.RND(1)) u1 (
        .clk(clk), .reset(reset),
        .A_data(A_data), .A_valid(A_valid), .A_last(A_last), .A_ready(ar[1]),
        .B_data(B_data), .B_valid(B_valid), .B_last(B_last), .B_ready(br[1]),
        .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready),
        .OF_saturation(OF_saturation), .UF_saturation(UF_saturation),
        .overflow(ovf_w[1]), .underflow(unf_w[1]), .last_err(le_w[1])
    );

    task automatic chk(string name, logic [63:0] got, logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic longint fdiv(longint x, longint den);
        return x >= 0 ? x / den : -((-x + den - 1) / den);
    endfunction

    // Accumulator counts 2^-18 units; result counts 2^-13 units, so one output LSB is 32 and half is 16
    function automatic exp_t expect_res(longint acc, bit rnd, bit of, bit uf, bit err);
        longint r, v;
        exp_t   e;
        r   = fdiv(acc + (rnd ? 16 : 0), 32);
        e.o = r > 524287;
        e.u = r < -524288;
        v   = (e.o && of) ? 524287 : (e.u && uf) ? -524288 : r;
        e.d = v[19:0];
        e.e = err;
        return e;
    endfunction

    task automatic model_beat(logic [31:0] a, logic [23:0] b, logic al, logic bl);
        for (int i = 0; i < 2; i++)
            macc += longint'($signed(a[i*16 +: 16])) * longint'($signed(b[i*12 +: 12]));
        mfirst = 0;
        if (al | bl) begin
            q0.push_back(expect_res(macc, 0, OF_saturation, UF_saturation, al ^ bl));
            q1.push_back(expect_res(macc, 1, OF_saturation, UF_saturation, al ^ bl));
            macc   = 0;
            mfirst = 1;
        end
    endtask

    // Called right after a negedge; returns right after a later negedge
    task automatic send_beat(logic [31:0] a, logic [23:0] b, logic al, logic bl);
        int t = 0;
        A_data = a; B_data = b; A_last = al; B_last = bl;
        A_valid = 1; B_valid = 1;
        #1;
        while (!ar[0]) begin
            if (++t > 300) begin
                checks++; errors++;
                $display("FAIL beat_timeout: A_ready stayed 0 for %0d cycles, expected 1", t);
                A_valid = 0; B_valid = 0;
                return;
            end
            @(negedge clk); #1;
        end
        if (mfirst) begin
            OF_saturation = of_next;
            UF_saturation = uf_next;
        end
        @(posedge clk);
        model_beat(a, b, al, bl);
        @(negedge clk);
        A_valid = 0; B_valid = 0;
    endtask

    task automatic send_uniform(logic [15:0] a, logic [11:0] b, int n, bit of, bit uf);
        of_next = of; uf_next = uf;
        for (int i = 0; i < n; i++) send_beat({a, a}, {b, b}, i == n - 1, i == n - 1);
    endtask

    task automatic idle(int n);
        repeat (n) begin
            if ($urandom_range(0, 1) == 1) begin
                A_valid = 1;
                #1 chk("a_ready_without_b", ar[0], 0);
                A_valid = 0;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", q0.size() + q1.size(), 0);
    endtask

    function automatic logic [15:0] ra();
        logic [15:0] v = 16'($urandom);
        return 16'($signed(v) >>> $urandom_range(0, 10));
    endfunction

    function automatic logic [11:0] rb();
        logic [11:0] v = 12'($urandom);
        return 12'($signed(v) >>> $urandom_range(0, 6));
    endfunction

    task automatic rand_frame();
        int n = $urandom_range(1, 16);
        int m = $urandom_range(0, 7);
        of_next = 1'($urandom);
        uf_next = 1'($urandom);
        for (int i = 0; i < n; i++) begin
            bit l = (i == n - 1);
            send_beat({ra(), ra()}, {rb(), rb()}, l && m != 1, l && m != 0);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
    endtask

    // Monitor: drives out_ready and compares every accepted result against the scoreboard
    initial begin
        bit   held[2];
        exp_t prev[2];
        exp_t got, e;
        bit   empty;
        held = '{0, 0};
        forever begin
            @(negedge clk);
            out_ready = !hold && $urandom_range(0, 3) != 0;
            if (!reset) begin
                held = '{0, 0};
            end else begin
                for (int k = 0; k < 2; k++) begin
                    got = {od[k], ovf_w[k], unf_w[k], le_w[k]};
                    if (!ov[k]) begin
                        held[k] = 0;
                    end else begin
                        if (held[k]) chk("held_stable", got, prev[k]);
                        if (out_ready) begin
                            empty = (k == 0) ? q0.size() == 0 : q1.size() == 0;
                            checks++;
                            if (empty) begin
                                errors++;
                                $display("FAIL out%0d_unexpected: got %h, expected no result", k, got);
                            end else begin
                                if (k == 0) e = q0.pop_front();
                                else e = q1.pop_front();
                                if (got !== e) begin
                                    errors++;
                                    $display("FAIL out%0d_result: got d=%h o=%b u=%b e=%b, expected d=%h o=%b u=%b e=%b",
                                             k, got.d, got.o, got.u, got.e, e.d, e.o, e.u, e.e);
                                end
                            end
                            held[k] = 0;
                        end else begin
                            held[k] = 1;
                            prev[k] = got;
                        end
                    end
                end
            end
        end
    end

    initial begin
        A_valid = 1; B_valid = 1;
        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_out_valid", ov[k], 0);
            chk("rst_out_data", od[k], 0);
            chk("rst_flags", {ovf_w[k], unf_w[k], le_w[k]}, 0);
            chk("rst_ready", {ar[k], br[k]}, 0);
        end
        A_valid = 0; B_valid = 0;
        @(negedge clk); reset = 1;
        @(negedge clk);

        send_uniform(16'h0400, 12'h100, 4, 1, 1);
        send_uniform(16'h7C00, 12'h700, 1, 1, 1);
        send_uniform(16'h7C00, 12'h700, 1, 0, 0);
        send_uniform(16'h8000, 12'h700, 1, 1, 1);
        send_uniform(16'h8000, 12'h700, 1, 0, 0);
        of_next = 1; uf_next = 1;
        send_beat({16'h0000, 16'h0001}, {12'h000, 12'h010}, 1, 1);
        send_beat({16'h0000, 16'hFFFF}, {12'h000, 12'h010}, 1, 1);
        send_beat({16'h0000, 16'hFFFF}, {12'h000, 12'hFF0}, 1, 1);
        for (int i = 0; i < 4; i++) send_beat({16'h0100, 16'h0200}, {12'h080, 12'h040}, i == 2, i == 3);
        wait_drain();

        hold = 1;
        @(negedge clk);
        fork
            begin
                send_uniform(16'h0800, 12'h100, 3, 1, 1);
                send_uniform(16'hF000, 12'h180, 3, 1, 1);
            end
            begin
                repeat (30) @(negedge clk);
                #2;
                chk("hold_a_ready", ar[0], 0);
                chk("hold_b_ready", br[0], 0);
                chk("hold_out_valid", ov[0], 1);
                hold = 0;
            end
        join
        wait_drain();

        for (int f = 0; f < 40; f++) begin
            rand_frame();
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        wait_drain();

        of_next = 1; uf_next = 1;
        for (int i = 0; i < 3; i++) send_beat({16'h1234, 16'h2345}, {12'h345, 12'h456}, 0, 0);
        A_valid = 1; B_valid = 1;
        reset = 0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("mid_rst_out_valid", ov[k], 0);
            chk("mid_rst_out_data", od[k], 0);
            chk("mid_rst_flags", {ovf_w[k], unf_w[k], le_w[k]}, 0);
            chk("mid_rst_ready", {ar[k], br[k]}, 0);
        end
        A_valid = 0; B_valid = 0;
        macc = 0; mfirst = 1;
        @(negedge clk); reset = 1;
        @(negedge clk);
        send_uniform(16'h0400, 12'h100, 4, 1, 1);
        wait_drain();

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
